// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: default geometry, derived
// sizes and the sequencer state encoding.
package conv_pkg;

    localparam int unsigned DEF_BITS        = 9;
    localparam int unsigned DEF_KERNEL_SIZE = 3;
    localparam int unsigned DEF_IMG_LENGTH  = 16;
    localparam int unsigned DEF_IMG_HEIGHT  = 16;
    localparam int unsigned DEF_MAC_LAT     = 2;

    localparam int unsigned KCOEFS = DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;
    localparam int unsigned NPIX   = DEF_IMG_LENGTH * DEF_IMG_HEIGHT;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoadK,
        StStream,
        StDrain,
        StDone
    } conv_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_tag_delay.sv
// Fixed-depth delay line for the per-pixel window/last tags, aligning them with
// the datapath MAC result. Synchronous flush empties the line.
module conv_tag_delay
    import conv_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_MAC_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic in_win,
    input  logic in_last,
    output logic out_win,
    output logic out_last
);

    logic [DEPTH-1:0] win_q;
    logic [DEPTH-1:0] last_q;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            win_q  <= '0;
            last_q <= '0;
        end else begin
            win_q[0]  <= in_win;
            last_q[0] <= in_last;
            for (int i = 1; i < int'(DEPTH); i++) begin
                win_q[i]  <= win_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign out_win  = win_q[DEPTH-1];
    assign out_last = last_q[DEPTH-1];

endmodule

// File: rtl/conv_sequencer.sv
// Frame sequencer for a streaming 2-D convolution core: loads the kernel, streams
// one frame of pixels into the datapath and tags/forwards the valid MAC results.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned BITS        = DEF_BITS,
    parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int unsigned IMG_LENGTH  = DEF_IMG_LENGTH,
    parameter int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT,
    parameter int unsigned MAC_LAT     = DEF_MAC_LAT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic            kernel_valid,
    input  logic [BITS-1:0] kernel_data,
    output logic            kernel_ready,
    input  logic            pix_valid,
    input  logic [BITS-1:0] pix_data,
    output logic            pix_ready,
    output logic            core_reset,
    output logic            kern_we,
    output logic [BITS-1:0] kern_wdata,
    output logic            img_we,
    output logic [BITS-1:0] img_wdata,
    input  logic            mac_valid,
    input  logic [BITS-1:0] mac_pixel,
    output logic            out_valid,
    output logic [BITS-1:0] out_pixel,
    output logic            out_last,
    output logic            busy,
    output logic            done,
    output logic            err_underrun,
    output logic            err_mac
);

    localparam int unsigned NumCoefs = KERNEL_SIZE * KERNEL_SIZE;
    localparam int unsigned KW = cnt_width(NumCoefs + 1);
    localparam int unsigned CW = cnt_width(IMG_LENGTH);
    localparam int unsigned RW = cnt_width(IMG_HEIGHT);
    localparam int unsigned DW = cnt_width(MAC_LAT);

    localparam logic [KW-1:0] KLast  = KW'(NumCoefs - 1);
    localparam logic [CW-1:0] ColMax = CW'(IMG_LENGTH - 1);
    localparam logic [RW-1:0] RowMax = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] ColWin = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] RowWin = RW'(KERNEL_SIZE - 1);
    localparam logic [DW-1:0] DLast  = DW'(MAC_LAT - 1);

    conv_state_e   state_q, state_d;
    logic [KW-1:0] kcnt_q, kcnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          err_underrun_q, err_underrun_d;
    logic          err_mac_q, err_mac_d;

    logic in_clear, in_load, in_stream, in_drain, in_done, in_busy, abort_hit;
    logic tag_win, tag_last, dly_win, dly_last;

    assign in_clear  = (state_q == StClear);
    assign in_load   = (state_q == StLoadK);
    assign in_stream = (state_q == StStream);
    assign in_drain  = (state_q == StDrain);
    assign in_done   = (state_q == StDone);
    assign in_busy   = in_clear | in_load | in_stream | in_drain;
    assign abort_hit = in_busy & abort;

    always_comb begin
        state_d        = state_q;
        kcnt_d         = kcnt_q;
        col_d          = col_q;
        row_d          = row_q;
        dcnt_d         = dcnt_q;
        err_underrun_d = err_underrun_q;
        err_mac_d      = err_mac_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) state_d = StClear;
            end
            StClear: begin
                kcnt_d  = '0;
                col_d   = '0;
                row_d   = '0;
                dcnt_d  = '0;
                state_d = StLoadK;
            end
            StLoadK: begin
                if (kernel_valid) begin
                    kcnt_d = kcnt_q + 1'b1;
                    if (kcnt_q == KLast) state_d = StStream;
                end
            end
            StStream: begin
                if (col_q == ColMax) begin
                    col_d = '0;
                    row_d = (row_q == RowMax) ? '0 : row_q + 1'b1;
                    if (row_q == RowMax) state_d = StDrain;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            StDrain: begin
                if (dcnt_q == DLast) state_d = StDone;
                else                 dcnt_d  = dcnt_q + 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_hit) state_d = StIdle;

        // Error flags are sticky within a frame and only cleared by the next CLEAR.
        if (in_clear) begin
            err_underrun_d = 1'b0;
            err_mac_d      = 1'b0;
        end else begin
            if (in_stream && !pix_valid) err_underrun_d = 1'b1;
            if (dly_win && !mac_valid)   err_mac_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            kcnt_q         <= '0;
            col_q          <= '0;
            row_q          <= '0;
            dcnt_q         <= '0;
            err_underrun_q <= 1'b0;
            err_mac_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            kcnt_q         <= kcnt_d;
            col_q          <= col_d;
            row_q          <= row_d;
            dcnt_q         <= dcnt_d;
            err_underrun_q <= err_underrun_d;
            err_mac_q      <= err_mac_d;
        end
    end

    // Tags for the pixel being written this cycle.
    assign tag_win  = img_we & (row_q >= RowWin) & (col_q >= ColWin);
    assign tag_last = img_we & (row_q == RowMax) & (col_q == ColMax);

    conv_tag_delay #(
        .DEPTH(MAC_LAT)
    ) u_tag_delay (
        .clk     (clk),
        .reset   (reset),
        .flush   (in_clear | abort_hit),
        .in_win  (tag_win),
        .in_last (tag_last),
        .out_win (dly_win),
        .out_last(dly_last)
    );

    // Every output except core_reset is forced low while reset is held.
    assign core_reset   = reset | in_clear | abort_hit;
    assign kernel_ready = in_load & ~reset;
    assign kern_we      = kernel_ready & kernel_valid;
    assign kern_wdata   = kernel_ready ? kernel_data : '0;
    assign pix_ready    = in_stream & ~reset;
    assign img_we       = pix_ready;
    assign img_wdata    = (img_we && pix_valid) ? pix_data : '0;
    assign out_valid    = dly_win & ~reset;
    assign out_pixel    = out_valid ? mac_pixel : '0;
    assign out_last     = out_valid & dly_last;
    assign busy         = in_busy & ~reset;
    assign done         = in_done & ~reset;
    assign err_underrun = err_underrun_q & ~reset;
    assign err_mac      = err_mac_q & ~reset;

endmodule

// File: tb/tb_conv_sequencer.sv
// Self-checking bench for conv_sequencer: a frame-level behavioural model checked
// every cycle, plus hand-computed per-frame totals.
module tb_conv_sequencer;
    import conv_pkg::*;

    localparam int unsigned BITS = 9;
    localparam int K   = 3;
    localparam int L   = 16;
    localparam int H   = 16;
    localparam int LAT = 2;
    localparam int KC  = K * K;
    localparam int NP  = L * H;

    logic            clk = 1'b0;
    logic            reset, start, abort;
    logic            kernel_valid, kernel_ready;
    logic [BITS-1:0] kernel_data;
    logic            pix_valid, pix_ready;
    logic [BITS-1:0] pix_data;
    logic            core_reset, kern_we, img_we;
    logic [BITS-1:0] kern_wdata, img_wdata;
    logic            mac_valid;
    logic [BITS-1:0] mac_pixel;
    logic            out_valid, out_last;
    logic [BITS-1:0] out_pixel;
    logic            busy, done, err_underrun, err_mac;

    always #5 clk = ~clk;

    conv_sequencer #(
        .BITS       (BITS),
        .KERNEL_SIZE(K),
        .IMG_LENGTH (L),
        .IMG_HEIGHT (H),
        .MAC_LAT    (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .kernel_valid(kernel_valid),
        .kernel_data (kernel_data),
        .kernel_ready(kernel_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_ready   (pix_ready),
        .core_reset  (core_reset),
        .kern_we     (kern_we),
        .kern_wdata  (kern_wdata),
        .img_we      (img_we),
        .img_wdata   (img_wdata),
        .mac_valid   (mac_valid),
        .mac_pixel   (mac_pixel),
        .out_valid   (out_valid),
        .out_pixel   (out_pixel),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .err_underrun(err_underrun),
        .err_mac     (err_mac)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Window tag (bit 0) and last-pixel tag (bit 1) of pixel index p.
    function automatic int tag_of(input int p);
        int r, c;
        r = p / L;
        c = p % L;
        return (((r >= K - 1) && (c >= K - 1)) ? 1 : 0) | ((p == NP - 1) ? 2 : 0);
    endfunction

    // Frame-level model: progress counted in coefficients taken, pixels written and
    // drain cycles spent; result tags travel through a LAT-entry queue.
    bit m_active = 0, m_clear = 0, m_done = 0, m_eu = 0, m_em = 0;
    int m_coefs = 0, m_pix = 0, m_drain = 0;
    int tagq[$] = '{0, 0};
    bit e_ld, e_st, was_done;
    int fr, new_tag;

    int n_kwe, n_iwe, n_ov, n_ol, n_done, kw_sum, last_iwe_cyc, done_cyc;

    always @(negedge clk) begin
        e_ld = m_active && !m_clear && (m_coefs < KC) && !reset;
        e_st = m_active && !m_clear && (m_coefs == KC) && (m_pix < NP) && !reset;
        fr   = reset ? 0 : tagq[0];

        check("busy", 32'(busy), 32'(m_active && !reset));
        check("done", 32'(done), 32'(m_done && !reset));
        check("core_reset", 32'(core_reset), 32'(reset || m_clear || (m_active && abort)));
        check("kernel_ready", 32'(kernel_ready), 32'(e_ld));
        check("kern_we", 32'(kern_we), 32'(e_ld && kernel_valid));
        if (e_ld && kernel_valid) check("kern_wdata", 32'(kern_wdata), 32'(kernel_data));
        check("pix_ready", 32'(pix_ready), 32'(e_st));
        check("img_we", 32'(img_we), 32'(e_st));
        if (e_st) check("img_wdata", 32'(img_wdata), pix_valid ? 32'(pix_data) : 32'd0);
        check("out_valid", 32'(out_valid), 32'(fr & 1));
        check("out_last", 32'(out_last), 32'(fr == 3));
        check("out_pixel", 32'(out_pixel), ((fr & 1) != 0) ? 32'(mac_pixel) : 32'd0);
        check("err_underrun", 32'(err_underrun), 32'(m_eu && !reset));
        check("err_mac", 32'(err_mac), 32'(m_em && !reset));

        if (kern_we) begin
            n_kwe++;
            kw_sum += int'(kern_wdata);
        end
        if (img_we) begin
            n_iwe++;
            last_iwe_cyc = cyc;
        end
        if (out_valid) n_ov++;
        if (out_last) n_ol++;
        if (done) begin
            n_done++;
            done_cyc = cyc;
        end

        // Advance the model across the coming clock edge.
        if (reset) begin
            m_active = 0; m_clear = 0; m_done = 0; m_eu = 0; m_em = 0;
            m_coefs = 0; m_pix = 0; m_drain = 0;
            tagq = '{0, 0};
        end else begin
            was_done = m_done;
            new_tag  = e_st ? tag_of(m_pix) : 0;
            if (m_clear) begin
                m_eu = 0;
                m_em = 0;
            end else begin
                if (e_st && !pix_valid) m_eu = 1;
                if (((fr & 1) != 0) && !mac_valid) m_em = 1;
            end
            void'(tagq.pop_front());
            tagq.push_back(new_tag);
            m_done = 0;
            if (m_active && abort) begin
                m_active = 0;
                m_clear  = 0;
                tagq     = '{0, 0};
            end else if (!m_active) begin
                if (!was_done && start && !abort) begin
                    m_active = 1; m_clear = 1; m_coefs = 0; m_pix = 0; m_drain = 0;
                end
            end else if (m_clear) begin
                m_clear = 0;
                tagq    = '{0, 0};
            end else if (e_ld) begin
                if (kernel_valid) m_coefs++;
            end else if (e_st) begin
                m_pix++;
            end else begin
                m_drain++;
                if (m_drain == LAT) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mac_pixel = BITS'(cyc * 37 + 5);
    endtask

    task automatic clr_counts();
        n_kwe = 0; n_iwe = 0; n_ov = 0; n_ol = 0; n_done = 0; kw_sum = 0;
        last_iwe_cyc = 0; done_cyc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_core_reset"}, 32'(core_reset), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_outs"}, 32'({out_valid, out_last, done, img_we, kern_we, pix_ready,
                                  kernel_ready, err_underrun, err_mac}), 32'd0);
        check({tag, "_data"}, 32'({img_wdata, kern_wdata, out_pixel}), 32'd0);
    endtask

    // One frame; gap/drop/abort/reset select the pixel index where each event occurs.
    task automatic run_frame(input int gap_pix, input int drop_pix, input int abort_pix,
                             input int reset_pix);
        start = 1; tick();
        start = 0; tick();
        for (int k = 0; k < KC; k++) begin
            kernel_valid = 1; kernel_data = BITS'(k + 1); tick();
            kernel_valid = 0; kernel_data = 0;
            if (k < KC - 1) begin
                start = (k == 3);
                tick();
                start = 0;
            end
        end
        for (int p = 0; p < NP; p++) begin
            pix_valid = (p != gap_pix);
            pix_data  = BITS'(p * 3 + 1);
            mac_valid = (p != drop_pix + LAT);
            abort     = (p == abort_pix);
            if (p == reset_pix) begin
                reset = 1;
                check_reset_outputs("reset_mid1");
                tick();
                check_reset_outputs("reset_mid2");
                tick();
                break;
            end
            if (p == abort_pix) begin
                @(negedge clk);
                check("abort_core_reset", 32'(core_reset), 32'd1);
                tick();
                break;
            end
            tick();
        end
        pix_valid = 0; pix_data = 0; mac_valid = 1; abort = 0; reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; abort = 0; kernel_valid = 0; kernel_data = 0;
        pix_valid = 0; pix_data = 0; mac_valid = 1; mac_pixel = 0;
        reset = 1;
        clr_counts();
        check_reset_outputs("reset_init");
        repeat (3) tick();
        reset = 0;
        repeat (2) tick();

        // Clean frame, with a start pulse ignored during kernel load.
        clr_counts();
        run_frame(-10, -10, -10, -10);
        repeat (6) tick();
        check("f1_kern_we_count", 32'(n_kwe), 32'd9);
        check("f1_kern_sum", 32'(kw_sum), 32'd45);
        check("f1_img_we_count", 32'(n_iwe), 32'd256);
        check("f1_out_valid_count", 32'(n_ov), 32'd196);
        check("f1_out_last_count", 32'(n_ol), 32'd1);
        check("f1_done_count", 32'(n_done), 32'd1);
        check("f1_done_latency", 32'(done_cyc - last_iwe_cyc), 32'd3);
        check("f1_errs", 32'({err_underrun, err_mac}), 32'd0);

        // Underrun on pixel 100.
        clr_counts();
        run_frame(100, -10, -10, -10);
        repeat (6) tick();
        check("f2_img_we_count", 32'(n_iwe), 32'd256);
        check("f2_out_valid_count", 32'(n_ov), 32'd196);
        check("f2_err_underrun", 32'(err_underrun), 32'd1);
        check("f2_err_mac", 32'(err_mac), 32'd0);

        // MAC result missing for the window of pixel 40; underrun flag must be cleared.
        clr_counts();
        run_frame(-10, 40, -10, -10);
        repeat (6) tick();
        check("f3_err_mac", 32'(err_mac), 32'd1);
        check("f3_err_underrun", 32'(err_underrun), 32'd0);
        check("f3_out_valid_count", 32'(n_ov), 32'd196);

        // Abort on pixel 50.
        run_frame(-10, -10, 50, -10);
        clr_counts();
        repeat (10) tick();
        check("f4_out_valid_after_abort", 32'(n_ov), 32'd0);
        check("f4_done_after_abort", 32'(n_done), 32'd0);
        check("f4_busy_after_abort", 32'(busy), 32'd0);

        // Abort and start together while idle: stays idle.
        start = 1; abort = 1; tick();
        start = 0; abort = 0;
        @(negedge clk);
        check("idle_abort_start_busy", 32'(busy), 32'd0);
        tick();

        // Reset in the middle of streaming.
        run_frame(-10, -10, -10, 30);
        clr_counts();
        repeat (10) tick();
        check("f5_out_valid_after_reset", 32'(n_ov), 32'd0);
        check("f5_done_after_reset", 32'(n_done), 32'd0);
        check("f5_busy_after_reset", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
